// File: rtl/argmax_stream_ctrl.sv
// Streaming argmax over one frame of N unsigned scores: tracks the running max and its index,
// then holds {index, value} on a valid/ready result handshake.
module argmax_stream_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 32,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_in_data,
  input  logic          i_in_last,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [IW-1:0] o_out_index,
  output logic [DW-1:0] o_out_value,
  output logic          o_busy,
  output logic          o_len_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StResult} state_e;

  state_e        r_state, w_state_d;
  logic [IW-1:0] r_cnt, w_cnt_d;
  logic [DW-1:0] r_max, w_max_d;
  logic [IW-1:0] r_idx, w_idx_d;
  logic [IW-1:0] r_out_idx, w_out_idx_d;
  logic [DW-1:0] r_out_val, w_out_val_d;
  logic          r_len_err, w_len_err_d;
  logic          w_is_last;

  assign w_is_last = (r_cnt == IW'(N - 1));

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_max_d     = r_max;
    w_idx_d     = r_idx;
    w_out_idx_d = r_out_idx;
    w_out_val_d = r_out_val;
    w_len_err_d = 1'b0;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StCollect;
          w_cnt_d   = '0;
        end
      end
      StCollect: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_cnt_d = r_cnt + IW'(1);
          if (r_cnt == '0) begin
            w_max_d = i_in_data;
            w_idx_d = '0;
          end else if (i_in_data > r_max) begin
            w_max_d = i_in_data;
            w_idx_d = r_cnt;
          end
          // in_last is only cross-checked against the count; N alone ends the frame
          w_len_err_d = (i_in_last != w_is_last);
          if (w_is_last) begin
            w_state_d   = StResult;
            w_cnt_d     = '0;
            w_out_idx_d = w_idx_d;
            w_out_val_d = w_max_d;
          end
        end
      end
      StResult: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Abort discards the frame without publishing a result or a length error.
    if (i_abort) begin
      w_state_d   = StIdle;
      w_cnt_d     = '0;
      w_len_err_d = 1'b0;
      w_out_idx_d = r_out_idx;
      w_out_val_d = r_out_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_out_idx <= '0;
      r_out_val <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_max     <= w_max_d;
      r_idx     <= w_idx_d;
      r_out_idx <= w_out_idx_d;
      r_out_val <= w_out_val_d;
      r_len_err <= w_len_err_d;
    end
  end

  assign o_out_index = r_out_idx;
  assign o_out_value = r_out_val;
  assign o_busy      = (r_state != StIdle);
  assign o_len_err   = r_len_err;

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Directed bench for argmax_stream_ctrl (N=8, DW=32) with hand-computed expected results.
module tb_argmax_stream_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 3;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic          i_abort;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_in_data;
  logic          i_in_last;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [IW-1:0] o_out_index;
  logic [DW-1:0] o_out_value;
  logic          o_busy;
  logic          o_len_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] scores [N];

  argmax_stream_ctrl #(
    .N  (N),
    .DW (DW)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_index (o_out_index),
    .o_out_value (o_out_value),
    .o_busy      (o_busy),
    .o_len_err   (o_len_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] data, input logic last, input logic exp_le);
    i_in_valid = 1'b1;
    i_in_data  = data;
    i_in_last  = last;
    tick();
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    check_eq("len_err", {31'd0, o_len_err}, {31'd0, exp_le});
  endtask

  // Starts a frame and streams scores[]; in_last marks beat last_pos; optional idle gaps.
  task automatic run_frame(input int last_pos, input bit gaps);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("collect_ready", {31'd0, o_in_ready}, 32'd1);
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) begin
        tick();
        tick();
        check_eq("stall_busy", {31'd0, o_busy}, 32'd1);
      end
      beat(scores[i], (i == last_pos), ((i == last_pos) != (i == N - 1)));
    end
  endtask

  task automatic expect_result(input logic [IW-1:0] idx, input logic [DW-1:0] val);
    check_eq("out_valid", {31'd0, o_out_valid}, 32'd1);
    check_eq("out_index", {29'd0, o_out_index}, {29'd0, idx});
    check_eq("out_value", o_out_value, val);
    check_eq("result_ready", {31'd0, o_in_ready}, 32'd0);
  endtask

  task automatic accept_result();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    check_eq("post_ack_valid", {31'd0, o_out_valid}, 32'd0);
    check_eq("post_ack_busy", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;

    check_eq("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_len_err", {31'd0, o_len_err}, 32'd0);
    check_eq("rst_index", {29'd0, o_out_index}, 32'd0);
    check_eq("rst_value", o_out_value, 32'd0);

    // Basic frame, tie at 12 keeps index 3
    scores = '{32'd5, 32'd9, 32'd3, 32'd12, 32'd7, 32'd12, 32'd1, 32'd0};
    run_frame(7, 1'b0);
    expect_result(3'd3, 32'd12);
    accept_result();
    check_eq("held_index", {29'd0, o_out_index}, 32'd3);

    // Unsigned compare
    scores = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_frame(7, 1'b0);
    expect_result(3'd1, 32'h8000_0000);
    accept_result();

    // Stalls inside the frame and 5 cycles of result backpressure
    scores = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd25, 32'd15, 32'd5, 32'd1};
    run_frame(7, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_result(3'd3, 32'd40);
    end
    accept_result();

    // in_last early on beat 4 and missing on beat 8
    scores = '{32'd4, 32'd4, 32'd8, 32'd8, 32'd2, 32'd2, 32'd1, 32'd1};
    run_frame(3, 1'b0);
    expect_result(3'd2, 32'd8);
    accept_result();

    // Abort after 5 beats, coinciding with a mismatched in_last beat
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'd100 * (i + 1), 1'b0, 1'b0);
    i_abort    = 1'b1;
    i_in_valid = 1'b1;
    i_in_data  = 32'd999;
    i_in_last  = 1'b1;
    tick();
    i_abort    = 1'b0;
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    check_eq("abort_busy", {31'd0, o_busy}, 32'd0);
    check_eq("abort_valid", {31'd0, o_out_valid}, 32'd0);
    check_eq("abort_len_err", {31'd0, o_len_err}, 32'd0);
    check_eq("abort_keeps_value", o_out_value, 32'd8);

    scores = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    run_frame(7, 1'b0);
    expect_result(3'd7, 32'd8);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_eq("rst_result_valid", {31'd0, o_out_valid}, 32'd0);
    check_eq("rst_result_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_result_index", {29'd0, o_out_index}, 32'd0);
    check_eq("rst_result_value", o_out_value, 32'd0);

    // start during COLLECT is ignored: the frame still ends after 8 beats
    scores = '{32'd7, 32'd1, 32'd1, 32'd9, 32'd3, 32'd9, 32'd2, 32'd6};
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_start = (i == 3);
      beat(scores[i], (i == N - 1), 1'b0);
      i_start = 1'b0;
      if (i < N - 1) check_eq("collect_no_result", {31'd0, o_out_valid}, 32'd0);
    end
    expect_result(3'd3, 32'd9);
    // start during RESULT is ignored
    i_start = 1'b1;
    tick();
    tick();
    i_start = 1'b0;
    expect_result(3'd3, 32'd9);
    accept_result();

    // abort and start together: abort wins
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    beat(32'd50, 1'b0, 1'b0);
    beat(32'd60, 1'b0, 1'b0);
    i_abort = 1'b1;
    i_start = 1'b1;
    tick();
    i_abort = 1'b0;
    i_start = 1'b0;
    check_eq("abort_start_busy", {31'd0, o_busy}, 32'd0);
    check_eq("abort_start_ready", {31'd0, o_in_ready}, 32'd0);
    tick();
    check_eq("idle_stays", {31'd0, o_busy}, 32'd0);
    check_eq("idle_no_valid", {31'd0, o_out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
